// File: rtl/cpu16_multicycle_ctrl.sv
// cpu16_multicycle_ctrl
//   Multicycle control unit for the 16-bit CPU. It steps one instruction
//   through FETCH, DECODE, EXEC, MEM and WB, and drives every datapath
//   select and write strobe. Memory accesses in FETCH and MEM stall until
//   i_mem_ready is high.
//
// Ports
//   i_clk         system clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_opcode      IR[15:12], only looked at in DECODE
//   i_zero        ALU zero flag, used by BEQ in EXEC
//   i_mem_ready   memory completes the current access this cycle
//   o_pc_write    PC load enable
//   o_pc_src      PC source: 00 PC+2, 01 branch target, 10 jump target
//   o_ir_write    instruction register load enable
//   o_mem_read    memory read request
//   o_mem_write   memory write request
//   o_reg_write   register-file write enable
//   o_reg_dst     destination register: 0 rt, 1 rd
//   o_mem_to_reg  write-back data: 0 ALU, 1 memory
//   o_alu_src     ALU B operand: 0 register, 1 sign-extended immediate
//   o_alu_op      ALU operation: 00 add, 01 sub, 10 funct field
//   o_state       current state (debug)
//   o_illegal     one-cycle pulse when an undefined opcode is decoded
//   o_halted      high while in HALT
module cpu16_multicycle_ctrl (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_opcode,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic       o_pc_write,
    output logic [1:0] o_pc_src,
    output logic       o_ir_write,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_reg_write,
    output logic       o_reg_dst,
    output logic       o_mem_to_reg,
    output logic       o_alu_src,
    output logic [1:0] o_alu_op,
    output logic [2:0] o_state,
    output logic       o_illegal,
    output logic       o_halted
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        OP_R    = 4'b0000,
        OP_ADDI = 4'b0001,
        OP_LW   = 4'b0010,
        OP_SW   = 4'b0011,
        OP_BEQ  = 4'b0100,
        OP_JMP  = 4'b0101,
        OP_HALT = 4'b1111
    } opcode_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_op;

    // State register and opcode capture
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_FETCH;
            r_op    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE) begin
                r_op <= i_opcode;
            end
        end
    end

    // Next-state logic; unused encodings fall back to FETCH
    always_comb begin
        w_next = ST_FETCH;
        case (r_state)
            ST_FETCH:  w_next = i_mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (i_opcode)
                    OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ: w_next = ST_EXEC;
                    OP_HALT:                             w_next = ST_HALT;
                    default:                             w_next = ST_FETCH;
                endcase
            end
            ST_EXEC: begin
                case (r_op)
                    OP_R, OP_ADDI: w_next = ST_WB;
                    OP_LW, OP_SW:  w_next = ST_MEM;
                    default:       w_next = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (!i_mem_ready) begin
                    w_next = ST_MEM;
                end else if (r_op == OP_LW) begin
                    w_next = ST_WB;
                end else begin
                    w_next = ST_FETCH;
                end
            end
            ST_WB:   w_next = ST_FETCH;
            ST_HALT: w_next = ST_HALT;
            default: w_next = ST_FETCH;
        endcase
    end

    // Output logic. DECODE looks at i_opcode directly because r_op is only
    // loaded at the end of that cycle. Everything is held at 0 while reset
    // is low so no strobe survives the asynchronous reset edge.
    always_comb begin
        o_pc_write   = 1'b0;
        o_pc_src     = 2'b00;
        o_ir_write   = 1'b0;
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        o_reg_write  = 1'b0;
        o_reg_dst    = 1'b0;
        o_mem_to_reg = 1'b0;
        o_alu_src    = 1'b0;
        o_alu_op     = 2'b00;
        o_illegal    = 1'b0;
        o_halted     = 1'b0;
        if (i_rst_n) begin
            case (r_state)
                ST_FETCH: begin
                    o_mem_read = 1'b1;
                    if (i_mem_ready) begin
                        o_ir_write = 1'b1;
                        o_pc_write = 1'b1;
                    end
                end
                ST_DECODE: begin
                    case (i_opcode)
                        OP_JMP: begin
                            o_pc_write = 1'b1;
                            o_pc_src   = 2'b10;
                        end
                        OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_HALT: ;
                        default: o_illegal = 1'b1;
                    endcase
                end
                ST_EXEC: begin
                    case (r_op)
                        OP_R:                 o_alu_op  = 2'b10;
                        OP_ADDI, OP_LW, OP_SW: o_alu_src = 1'b1;
                        OP_BEQ: begin
                            o_alu_op = 2'b01;
                            if (i_zero) begin
                                o_pc_write = 1'b1;
                                o_pc_src   = 2'b01;
                            end
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    o_mem_read  = (r_op == OP_LW);
                    o_mem_write = (r_op == OP_SW);
                end
                ST_WB: begin
                    o_reg_write  = 1'b1;
                    o_reg_dst    = (r_op == OP_R);
                    o_mem_to_reg = (r_op == OP_LW);
                end
                ST_HALT: o_halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign o_state = r_state;

endmodule

// File: doc/cpu16_multicycle_ctrl.md
# cpu16_multicycle_ctrl

Multicycle control unit for the 16-bit CPU. It sequences a single instruction through fetch, decode, execute, memory and write-back, and drives every datapath select and write strobe. Those include the select of the 2-bit register-address 2:1 mux (RegDst: rt vs rd) and the 2-bit PC-source select. A simple ready handshake with memory lets fetch and load/store stall for slow memory.

## Interface
Parameters:
- none (opcode map fixed below)

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- OpCode  in  4  IR[15:12]; valid from the cycle after IRWrite.
- Zero  in  1  ALU zero flag, sampled in EXEC for BEQ.
- MemReady  in  1  memory completes the current access this cycle.
- PCWrite  out  1  PC register load enable.
- PCSrc  out  2  selects the PC source: 00 PC+2, 01 branch target, 10 jump target.
- IRWrite  out  1  instruction register load enable.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- RegWrite  out  1  register-file write enable.
- RegDst  out  1  S input of the 2-bit destination-address mux: 0 selects rt, 1 selects rd.
- MemToReg  out  1  write-back data: 0 selects ALU, 1 selects memory.
- ALUSrc  out  1  ALU B operand: 0 selects register, 1 selects sign-extended immediate.
- ALUOp  out  2  ALU operation: 00 add, 01 sub, 10 use funct field.
- State  out  3  current state, for debug and test.
- Illegal  out  1  one-cycle pulse when an undefined opcode is decoded.
- Halted  out  1  high while in HALT.

## Operation
Opcode map:
- 0000 R
- 0001 ADDI
- 0010 LW
- 0011 SW
- 0100 BEQ
- 0101 JMP
- 1111 HALT
- all other opcodes are illegal.

States (State encoding): FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Encodings 6 and 7 go to FETCH on the next edge.

Opcode capture: OpCode is registered into op_q in DECODE. All later states decode op_q, not OpCode.

Outputs are combinational from state, op_q, Zero and MemReady. Every output not listed for a state is 0.

- FETCH: MemRead=1.
  - MemReady=0: remain in FETCH.
  - MemReady=1: IRWrite=1, PCWrite=1, PCSrc=00; go to DECODE.
- DECODE: capture op_q.
  - JMP: PCWrite=1, PCSrc=10; go to FETCH.
  - HALT: go to HALT.
  - Illegal opcode: Illegal=1; go to FETCH. The PC has already advanced, so the illegal instruction behaves as a NOP.
  - Any other opcode: go to EXEC.
- EXEC:
  - R: ALUSrc=0, ALUOp=10; go to WB.
  - ADDI: ALUSrc=1, ALUOp=00; go to WB.
  - LW/SW: ALUSrc=1, ALUOp=00; go to MEM.
  - BEQ: ALUSrc=0, ALUOp=01; if Zero=1, PCWrite=1 and PCSrc=01; go to FETCH.
- MEM:
  - LW: MemRead=1. Remain in MEM until MemReady=1, then go to WB.
  - SW: MemWrite=1. Remain in MEM until MemReady=1, then go to FETCH.
  - Strobes stay constant throughout the wait.
- WB: RegWrite=1; go to FETCH.
  - R: RegDst=1.
  - ADDI: RegDst=0.
  - LW: RegDst=0, MemToReg=1.
- HALT: Halted=1, all strobes 0. Remains in HALT until Reset.

## Timing
- Reset (Reset=0) is asynchronous.
  - State becomes FETCH and op_q becomes 0000.
  - All strobe outputs and Illegal are forced to 0 while Reset is low.
  - Halted=0 and State=0 during reset.
- The first fetch request (MemRead=1) appears in the first cycle after Reset deasserts.
- Latency in cycles, counting from the FETCH cycle with MemReady=1 and assuming zero wait states:
  - JMP 2
  - BEQ 3
  - R 4
  - ADDI 4
  - SW 4
  - LW 5
  - Illegal opcode 2
- Each memory wait cycle adds one cycle to the corresponding state.
- PCWrite is asserted for exactly one cycle per FETCH, plus at most one more cycle for a taken BEQ or a JMP. PCWrite is never asserted in WB or MEM.
- RegWrite and MemWrite are never asserted in the same cycle.
- MemReady is ignored outside FETCH and MEM.
- A Zero change in a non-EXEC state has no effect.
- Reset asserted mid-instruction (any state, including MEM with a pending access) aborts the instruction immediately. No strobe remains high after the asynchronous reset edge.

## Test plan
- Reset released with MemReady=1 and an ADD R-type instruction (OpCode=0000):
  - State sequence 0,1,2,4,0.
  - RegWrite=1 with RegDst=1 only in WB.
  - PCWrite pulses once.
- LW (OpCode=0010) with MemReady low for 2 cycles in MEM:
  - State sequence 0,1,2,3,3,3,4.
  - MemRead held high through all three MEM cycles.
  - In WB: MemToReg=1, RegDst=0.
- BEQ (OpCode=0100) run twice, first with Zero=1, then with Zero=0:
  - Zero=1: in EXEC, PCWrite=1 with PCSrc=01.
  - Zero=0: PCWrite=0 in EXEC.
  - Both return to FETCH after 3 cycles.
- JMP (OpCode=0101), then OpCode=1010:
  - JMP: PCWrite=1 with PCSrc=10 in DECODE.
  - OpCode=1010: Illegal pulses for 1 cycle, then State=0.
- HALT (OpCode=1111):
  - Halted=1 stays high for 20 cycles with all strobes 0.
  - Reset pulse: State=0, Halted=0.
- SW (OpCode=0011) with MemReady=0 in MEM, then Reset asserted asynchronously mid-cycle:
  - MemWrite drops to 0 immediately.
  - After release, State=0 and a fetch restarts.
